sync_filter_edge: RTL
=====================

Name: sync_filter_edge

Overview:
- Parametrised multi-channel clock-domain-crossing input conditioner.
- Each channel runs an N-stage flip-flop synchronizer, then a stability (debounce) filter, then rise/fall edge detection.
- Sits at the boundary between asynchronous pins (buttons, external status lines, slow-domain flags) and clk-domain control logic.
- Replaces ad-hoc 2-FF synchronizers with one configurable, glitch-rejecting block.

Parameters:
- NUM_CH, 4: number of independent channels (≥1).
- SYNC_STAGES, 2: synchronizer flip-flop depth (≥2).
- FILTER_CYCLES, 4: consecutive cycles a new value must persist before the filtered output accepts it (≥1).
- RESET_VAL, {NUM_CH{1'b0}}: per-channel reset value of the synchronizer stages and the filtered level.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- async_in  input  NUM_CH  asynchronous inputs, one bit per channel.
- sync_out  output  NUM_CH  synchronized, filtered level.
- rise_pulse  output  NUM_CH  one-cycle pulse on a filtered 0->1 transition.
- fall_pulse  output  NUM_CH  one-cycle pulse on a filtered 1->0 transition.
- any_edge  output  1  OR of all rise_pulse and fall_pulse bits, registered together with them.

Behaviour:
- Reset is asynchronous, active-low, clock clk.
- During reset:
  - all synchronizer stages[i] = RESET_VAL[i]; sync_out[i] = RESET_VAL[i];
  - filter counters = 0;
  - rise_pulse = fall_pulse = 0; any_edge = 0.
- Reset asserted mid-operation discards the synchronizer contents and any partial filter count immediately. No pulse is generated on entry to or exit from reset.
- Synchronizer, per channel:
  - stage[0] <= async_in[i]; stage[k] <= stage[k-1].
  - s[i] = stage[SYNC_STAGES-1].
  - No logic between stages.
- Filter, per channel:
  - Counter cnt, width $clog2(FILTER_CYCLES+1).
  - If s == sync_out: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: sync_out <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return of s to the sync_out value before the count completes clears cnt, so the run of consecutive cycles restarts.
- Latency: a clean input step sampled at edge E0 appears on sync_out after edge E0+SYNC_STAGES+FILTER_CYCLES-1. With the defaults, sync_out changes on the 6th rising edge counting E0 as the 1st.
- Edge pulses:
  - rise_pulse[i] <= (filter update this cycle) && s==1.
  - fall_pulse[i] <= (filter update this cycle) && s==0.
  - The pulse is high for exactly the first cycle in which sync_out shows the new value.
  - rise_pulse and fall_pulse are never both high on the same channel.
- any_edge is registered and coincident with the pulses. Simultaneous events on several channels assert any_edge for one cycle only.
- Channels are fully independent; no cross-channel ordering guarantee (inherent to CDC).
- FILTER_CYCLES=1: sync_out follows s with one cycle of registration.
- Sustained toggling faster than FILTER_CYCLES never changes sync_out.
- Counter saturation cannot occur; cnt never exceeds FILTER_CYCLES-1.
- All outputs are registered; there are no combinational paths from async_in.

Decomposition:
- Shared package cdc_pkg:
  - SYNC_STAGES_MIN = 2 constant;
  - helper function for counter width;
  - elaboration-time parameter legality checks (SYNC_STAGES ≥ 2, FILTER_CYCLES ≥ 1, NUM_CH ≥ 1).
- Sub-module sync_filter_ch: one channel, containing the synchronizer, filter counter, level register and pulse registers.
- The top instantiates sync_filter_ch NUM_CH times via a generate loop and registers any_edge.
- Synchronizer flops carry the team's CDC/ASYNC_REG attribute.

Test Plan:
- Reset/default: hold reset_n=0 with async_in=4'hF, release -> sync_out=4'h0 and no pulses during reset. sync_out becomes 4'hF after 6 edges; rise_pulse=4'hF for exactly 1 cycle; any_edge=1 for 1 cycle.
- Latency (defaults): async_in[0] 0->1 held -> sync_out[0] rises exactly 6 edges after the first sampling edge, coincident with a single rise_pulse[0] cycle. The same check applies for 1->0 with fall_pulse[0].
- Glitch rejection:
  - async_in[1] high for 3 cycles then low -> sync_out[1] stays 0, no pulses.
  - Repeat with a 4-cycle pulse -> sync_out[1]=1 for ≥1 cycle, then rise_pulse and, 4 cycles later, fall_pulse.
- Interrupted count: async_in[2] high 3 cycles, low 1 cycle, high 4 cycles -> exactly one rise, timed from the start of the second high run.
- Reset mid-count: assert reset_n with cnt=2 on channel 3 -> sync_out[3]=0 and cnt=0 immediately. After release, the held input needs the full 6 edges; no spurious pulse.
- Parameter sweep: NUM_CH=1, SYNC_STAGES=3, FILTER_CYCLES=1, RESET_VAL=1 -> reset level 1; a falling step appears after 4 edges with a single fall_pulse.

Source files
------------

// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_pkg
// Description : Shared constants, types and elaboration helpers for the
//               clock-domain-crossing input conditioner.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

  // Two flops is the minimum depth that gives metastability time to resolve.
  localparam int SYNC_STAGES_MIN = 2;

  // Next-cycle edge decision of one channel.  The top uses it to build a
  // registered any_edge that lines up with the channels' own pulse flops.
  typedef struct packed {
    logic rise;
    logic fall;
  } edge_pair_t;

  // Width of a counter that must hold 0..filter_cycles.  Never below 1.
  function automatic int cnt_width(input int filter_cycles);
    return ($clog2(filter_cycles + 1) < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

  // Legal parameter set for the conditioner.
  function automatic bit params_legal(input int num_ch,
                                      input int sync_stages,
                                      input int filter_cycles);
    return (num_ch >= 1) && (sync_stages >= SYNC_STAGES_MIN) &&
           (filter_cycles >= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_filter_edge_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_edge_if
// Description : Signal bundle between asynchronous pins and the conditioner.
// Ports       : async_in   - raw asynchronous inputs, one bit per channel
//               sync_out   - synchronized, filtered level
//               rise_pulse - one-cycle pulse on a filtered 0->1 transition
//               fall_pulse - one-cycle pulse on a filtered 1->0 transition
//               any_edge   - OR of all pulses, coincident with them
//               master modport: drives async_in (pin side / testbench)
//               slave  modport: the conditioner itself
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_filter_edge_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] async_in;
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic              any_edge;

  modport master (
    output async_in,
    input  sync_out,
    input  rise_pulse,
    input  fall_pulse,
    input  any_edge
  );

  modport slave (
    input  async_in,
    output sync_out,
    output rise_pulse,
    output fall_pulse,
    output any_edge
  );
endinterface
`default_nettype wire

// File: rtl/sync_filter_ch.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_ch
// Description : One conditioner channel: N-flop synchronizer, stability
//               filter and registered rise/fall pulse generation.
// Ports       : clk        - system clock
//               reset_n    - asynchronous, active-low reset
//               async_in   - raw asynchronous input
//               sync_out   - filtered level (registered)
//               rise_pulse - registered pulse, first cycle of a new 1 level
//               fall_pulse - registered pulse, first cycle of a new 0 level
//               edge_next  - pulse values that load on the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter_ch
  import cdc_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       async_in,
  output logic       sync_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output edge_pair_t edge_next
);

  localparam int                c_cnt_w    = cnt_width(FILTER_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_level;
  logic               r_rise;
  logic               r_fall;
  logic               w_s;
  logic               w_update;

  // Pure flop chain; nothing may sit between the stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // The counter holds the number of consecutive cycles the synchronized
  // value has already disagreed with the level; the current disagreeing
  // cycle completes the run when the count has reached FILTER_CYCLES-1.
  assign w_update = (w_s != r_level) && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_level <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_update & w_s;
      r_fall <= w_update & ~w_s;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign sync_out       = r_level;
  assign rise_pulse     = r_rise;
  assign fall_pulse     = r_fall;
  assign edge_next.rise = w_update & w_s;
  assign edge_next.fall = w_update & ~w_s;

endmodule
`default_nettype wire

// File: rtl/sync_filter_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_edge
// Description : Multi-channel CDC input conditioner.  Each channel is a
//               synchronizer + debounce filter + edge detector; any_edge is
//               a registered OR of every channel's pulses.
// Ports       : clk     - system clock
//               reset_n - asynchronous, active-low reset
//               bus     - sync_filter_edge_if slave: async_in in; sync_out,
//                         rise_pulse, fall_pulse, any_edge out
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter_edge
  import cdc_pkg::*;
#(
  parameter int                NUM_CH        = 4,
  parameter int                SYNC_STAGES   = 2,
  parameter int                FILTER_CYCLES = 4,
  parameter logic [NUM_CH-1:0] RESET_VAL     = {NUM_CH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  sync_filter_edge_if.slave bus
);

  if (!params_legal(NUM_CH, SYNC_STAGES, FILTER_CYCLES)) begin : g_param_check
    $error("sync_filter_edge: illegal NUM_CH/SYNC_STAGES/FILTER_CYCLES");
  end

  edge_pair_t [NUM_CH-1:0] w_edge;
  logic       [NUM_CH-1:0] w_any_bits;
  logic       [NUM_CH-1:0] w_sync;
  logic       [NUM_CH-1:0] w_rise;
  logic       [NUM_CH-1:0] w_fall;
  logic                    r_any_edge;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_filter_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL    (RESET_VAL[i])
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .async_in  (bus.async_in[i]),
      .sync_out  (w_sync[i]),
      .rise_pulse(w_rise[i]),
      .fall_pulse(w_fall[i]),
      .edge_next (w_edge[i])
    );
    assign w_any_bits[i] = w_edge[i].rise | w_edge[i].fall;
  end

  // Built from next-cycle pulse values so it lands on the same edge as the
  // channel pulse flops instead of being a combinational OR of them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_any_edge <= 1'b0;
    end else begin
      r_any_edge <= |w_any_bits;
    end
  end

  assign bus.sync_out   = w_sync;
  assign bus.rise_pulse = w_rise;
  assign bus.fall_pulse = w_fall;
  assign bus.any_edge   = r_any_edge;

endmodule
`default_nettype wire
